// File: rtl/bus_seq_pkg.sv
// Shared state encoding, microcode word layout and bus select codes for bus_sequencer.
package bus_seq_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t StReset = 3'd0;
  localparam seq_state_t StFetch = 3'd1;
  localparam seq_state_t StExec  = 3'd2;
  localparam seq_state_t StHalt  = 3'd3;
  localparam seq_state_t StGrant = 3'd4;

  localparam logic [2:0] ADDR_NONE = 3'd0;
  localparam logic [2:0] ADDR_SP   = 3'd1;
  localparam logic [2:0] ADDR_MAR  = 3'd2;
  localparam logic [2:0] ADDR_X    = 3'd3;
  localparam logic [2:0] ADDR_PC   = 3'd5;

  localparam logic [3:0] OUT_A     = 4'b0001;
  localparam logic [3:0] OUT_ALU   = 4'b0010;
  localparam logic [3:0] OUT_MEM   = 4'b0011;
  localparam logic [3:0] LOAD_A    = 4'b0001;
  localparam logic [3:0] LOAD_MEM  = 4'b0011;
  localparam logic [3:0] LOAD_IR   = 4'b0100;
  localparam logic [3:0] LOAD_B    = 4'b0101;
  localparam logic [3:0] SEL_IDLE  = 4'b1000;

  localparam logic [7:0] OPC_LDA   = 8'h01;
  localparam logic [7:0] OPC_STC   = 8'h02;
  localparam logic [7:0] OPC_SPIN  = 8'h03;
  localparam logic [7:0] OPC_HLT   = 8'h0F;

  typedef struct packed {
    logic       eoi;
    logic       hlt;
    logic       cond;
    logic [2:0] addrout;
    logic [2:0] addrload;
    logic [3:0] out;
    logic [3:0] load;
  } uword_t;

  function automatic uword_t mk_word(input logic eoi, input logic hlt, input logic cond,
                                     input logic [2:0] addrout, input logic [2:0] addrload,
                                     input logic [3:0] out, input logic [3:0] load);
    uword_t w;
    w.eoi      = eoi;
    w.hlt      = hlt;
    w.cond     = cond;
    w.addrout  = addrout;
    w.addrload = addrload;
    w.out      = out;
    w.load     = load;
    return w;
  endfunction

endpackage

// File: rtl/bus_sequencer_rom.sv
// microcode_rom: combinational {opcode, step} -> control word lookup.
module microcode_rom
  import bus_seq_pkg::*;
#(
  parameter int unsigned OPC_W  = 8,
  parameter int unsigned STEP_W = 3
) (
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [STEP_W-1:0] i_step,
  output uword_t            o_word
);

  always_comb begin
    // Unlisted opcode/step pairs end the instruction with everything idle.
    o_word = mk_word(1'b1, 1'b0, 1'b0, ADDR_NONE, ADDR_NONE, SEL_IDLE, SEL_IDLE);
    case (i_opcode)
      OPC_W'(OPC_LDA): begin
        if (i_step == STEP_W'(1)) begin
          o_word = mk_word(1'b0, 1'b0, 1'b0, ADDR_PC, ADDR_MAR, SEL_IDLE, SEL_IDLE);
        end else if (i_step == STEP_W'(2)) begin
          o_word = mk_word(1'b1, 1'b0, 1'b0, ADDR_MAR, ADDR_NONE, OUT_MEM, LOAD_A);
        end
      end
      OPC_W'(OPC_STC): begin
        if (i_step == STEP_W'(1)) begin
          o_word = mk_word(1'b1, 1'b0, 1'b1, ADDR_PC, ADDR_MAR, OUT_A, LOAD_MEM);
        end
      end
      // Never raises eoi: relies on the step-overflow terminator.
      OPC_W'(OPC_SPIN): begin
        o_word = mk_word(1'b0, 1'b0, 1'b0, ADDR_SP, ADDR_X, OUT_ALU, LOAD_B);
      end
      OPC_W'(OPC_HLT): begin
        o_word = mk_word(1'b1, 1'b1, 1'b0, ADDR_NONE, ADDR_NONE, SEL_IDLE, SEL_IDLE);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Microstep sequencer driving address/data bus selects, with loader bus handover.
// Optional BUS_SEQ_COND_EN: cond words suppress load selects when cond_flag is low.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned STEP_W = 3,
  parameter int unsigned OPC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              cond_flag,
  input  logic              bus_req,
  output logic              bus_grant,
  output logic [2:0]        addroutctl,
  output logic [2:0]        addrloadctl,
  output logic [3:0]        outctl,
  output logic [3:0]        loadctl,
  output logic [STEP_W-1:0] step,
  output logic              halted,
  output logic              ucode_err
);

  seq_state_t        r_state;
  logic [STEP_W-1:0] r_step;
  logic              r_err;
  logic              r_from_halt;

  uword_t            w_word;
  logic              w_step_max;
  logic              w_suppress;

  microcode_rom #(
    .OPC_W  (OPC_W),
    .STEP_W (STEP_W)
  ) u_rom (
    .i_opcode (opcode),
    .i_step   (r_step),
    .o_word   (w_word)
  );

  assign w_step_max = &r_step;

`ifdef BUS_SEQ_COND_EN
  assign w_suppress = w_word.cond & ~cond_flag;
`else
  logic w_unused_cond;
  assign w_suppress    = 1'b0;
  assign w_unused_cond = cond_flag ^ w_word.cond;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StReset;
      r_step      <= '0;
      r_err       <= 1'b0;
      r_from_halt <= 1'b0;
    end else begin
      case (r_state)
        StReset: begin
          r_state <= StFetch;
          r_step  <= '0;
        end
        StFetch: begin
          r_state <= StExec;
          r_step  <= STEP_W'(1);
        end
        StExec: begin
          if (w_word.hlt) begin
            r_state <= StHalt;
            r_step  <= '0;
          end else if (w_word.eoi || w_step_max) begin
            if (!w_word.eoi) r_err <= 1'b1;
            // bus_req is only looked at here and in HALT.
            r_state     <= bus_req ? StGrant : StFetch;
            r_from_halt <= 1'b0;
            r_step      <= '0;
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        StHalt: begin
          if (bus_req) begin
            r_state     <= StGrant;
            r_from_halt <= 1'b1;
          end
        end
        StGrant: begin
          if (!bus_req) r_state <= r_from_halt ? StHalt : StFetch;
        end
        default: begin
          r_state <= StReset;
          r_step  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    addroutctl  = ADDR_NONE;
    addrloadctl = ADDR_NONE;
    outctl      = SEL_IDLE;
    loadctl     = SEL_IDLE;
    case (r_state)
      StFetch: begin
        addroutctl = ADDR_PC;
        outctl     = OUT_MEM;
        loadctl    = LOAD_IR;
      end
      StExec: begin
        addroutctl  = w_word.addrout;
        addrloadctl = w_suppress ? ADDR_NONE : w_word.addrload;
        outctl      = w_word.out;
        loadctl     = w_suppress ? SEL_IDLE : w_word.load;
      end
      default: ;
    endcase
  end

  assign bus_grant = (r_state == StGrant);
  assign halted    = (r_state == StHalt) || ((r_state == StGrant) && r_from_halt);
  assign step      = r_step;
  assign ucode_err = r_err;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: vector table, directed corner cases, random run.
module tb_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] opcode = 8'h00;
  logic       cond_flag = 1'b0;
  logic       bus_req = 1'b0;
  logic       bus_grant;
  logic [2:0] addroutctl;
  logic [2:0] addrloadctl;
  logic [3:0] outctl;
  logic [3:0] loadctl;
  logic [2:0] step;
  logic       halted;
  logic       ucode_err;

  int n_checks = 0;
  int n_err    = 0;
  logic m_err  = 1'b0;

  bus_sequencer #(
    .STEP_W (3),
    .OPC_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .cond_flag   (cond_flag),
    .bus_req     (bus_req),
    .bus_grant   (bus_grant),
    .addroutctl  (addroutctl),
    .addrloadctl (addrloadctl),
    .outctl      (outctl),
    .loadctl     (loadctl),
    .step        (step),
    .halted      (halted),
    .ucode_err   (ucode_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       eoi;
    logic       hlt;
    logic       cond;
    logic [2:0] ao;
    logic [2:0] al;
    logic [3:0] o;
    logic [3:0] l;
  } w_t;

  typedef struct packed {
    logic       grant;
    logic [2:0] ao;
    logic [2:0] al;
    logic [3:0] o;
    logic [3:0] l;
    logic [2:0] step;
    logic       halted;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] opc;
    int         k;
    logic       cf;
    logic [2:0] ao;
    logic [2:0] al;
    logic [3:0] o;
    logic [3:0] l;
  } vec_t;

  // Reference microprogram as documented for each opcode.
  function automatic w_t ref_word(input logic [7:0] opc, input int k);
    w_t w;
    w = '{eoi: 1'b1, hlt: 1'b0, cond: 1'b0, ao: 3'd0, al: 3'd0, o: 4'd8, l: 4'd8};
    if (opc == 8'h01 && k == 1) w = '{1'b0, 1'b0, 1'b0, 3'd5, 3'd2, 4'd8, 4'd8};
    if (opc == 8'h01 && k == 2) w = '{1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 4'd3, 4'd1};
    if (opc == 8'h02 && k == 1) w = '{1'b1, 1'b0, 1'b1, 3'd5, 3'd2, 4'd1, 4'd3};
    if (opc == 8'h03)           w = '{1'b0, 1'b0, 1'b0, 3'd1, 3'd3, 4'd2, 4'd5};
    if (opc == 8'h0F && k == 1) w = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 4'd8, 4'd8};
    return w;
  endfunction

  function automatic exp_t e_idle(input logic g, input logic h, input logic err);
    exp_t e;
    e = '{grant: g, ao: 3'd0, al: 3'd0, o: 4'd8, l: 4'd8, step: 3'd0, halted: h, err: err};
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic err);
    exp_t e;
    e = e_idle(1'b0, 1'b0, err);
    e.ao = 3'd5;
    e.o  = 4'd3;
    e.l  = 4'd4;
    return e;
  endfunction

  function automatic exp_t e_exec(input w_t w, input int k, input logic cf, input logic err);
    exp_t e;
    logic gate_en;
`ifdef BUS_SEQ_COND_EN
    gate_en = 1'b1;
`else
    gate_en = 1'b0;
`endif
    e = e_idle(1'b0, 1'b0, err);
    e.ao = w.ao;
    e.al = w.al;
    e.o  = w.o;
    e.l  = w.l;
    e.step = 3'(k);
    if (gate_en && w.cond && !cf) begin
      e.al = 3'd0;
      e.l  = 4'd8;
    end
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = '{grant: bus_grant, ao: addroutctl, al: addrloadctl, o: outctl, l: loadctl,
          step: step, halted: halted, err: ucode_err};
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: actual grant=%b ao=%0d al=%0d out=%0d ld=%0d step=%0d halt=%b err=%b | required grant=%b ao=%0d al=%0d out=%0d ld=%0d step=%0d halt=%b err=%b",
               name, a.grant, a.ao, a.al, a.o, a.l, a.step, a.halted, a.err,
               e.grant, e.ao, e.al, e.o, e.l, e.step, e.halted, e.err);
    end
  endtask

  // One cycle: drive at the falling edge, settle, caller then checks.
  task automatic cyc(input logic r, input logic [7:0] opc, input logic req, input logic cf);
    @(negedge clk);
    rst = r;
    opcode = opc;
    bus_req = req;
    cond_flag = cf;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    m_err = 1'b0;
    check("reset_state", e_idle(1'b0, 1'b0, 1'b0));
  endtask

  task automatic grant_phase(input logic from_halt);
    logic req;
    for (int i = 0; i < 8; i++) begin
      req = (i < 7) ? ($urandom_range(0, 2) != 0) : 1'b0;
      cyc(1'b0, opcode, req, $urandom_range(0, 1) == 1);
      check("grant", e_idle(1'b1, from_halt, m_err));
      if (!req) break;
    end
  endtask

  // Fetch plus exec steps of one instruction; returns whether it halted.
  task automatic run_instr(input logic [7:0] opc, input logic force_req, output logic hlt_o);
    w_t   w;
    logic req;
    logic cf;
    hlt_o = 1'b0;
    cyc(1'b0, opc, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    check("fetch", e_fetch(m_err));
    for (int k = 1; k <= 7; k++) begin
      w   = ref_word(opc, k);
      req = force_req | ($urandom_range(0, 1) == 1);
      cf  = ($urandom_range(0, 1) == 1);
      cyc(1'b0, opc, req, cf);
      check("exec", e_exec(w, k, cf, m_err));
      if (w.hlt) begin
        hlt_o = 1'b1;
        break;
      end
      if (w.eoi || k == 7) begin
        if (!w.eoi) m_err = 1'b1;
        if (req) grant_phase(1'b0);
        break;
      end
    end
  endtask

  task automatic halt_phase();
    logic req;
    for (int i = 0; i < 5; i++) begin
      req = ($urandom_range(0, 2) == 0);
      cyc(1'b0, opcode, req, 1'b0);
      check("halt", e_idle(1'b0, 1'b1, m_err));
      if (req) grant_phase(1'b1);
    end
  endtask

  vec_t       vecs[7];
  logic       hflag;
  exp_t       e;
  logic [7:0] opc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h01, 1, 1'b0, 3'd5, 3'd2, 4'd8, 4'd8};
    vecs[1] = '{8'h01, 2, 1'b1, 3'd2, 3'd0, 4'd3, 4'd1};
    vecs[2] = '{8'h02, 1, 1'b1, 3'd5, 3'd2, 4'd1, 4'd3};
`ifdef BUS_SEQ_COND_EN
    vecs[3] = '{8'h02, 1, 1'b0, 3'd5, 3'd0, 4'd1, 4'd8};
`else
    vecs[3] = '{8'h02, 1, 1'b0, 3'd5, 3'd2, 4'd1, 4'd3};
`endif
    vecs[4] = '{8'h03, 7, 1'b0, 3'd1, 3'd3, 4'd2, 4'd5};
    vecs[5] = '{8'h0F, 1, 1'b0, 3'd0, 3'd0, 4'd8, 4'd8};
    vecs[6] = '{8'h55, 1, 1'b1, 3'd0, 3'd0, 4'd8, 4'd8};

    // Reset then fetch one cycle after release.
    do_reset();
    cyc(1'b0, 8'h01, 1'b0, 1'b0);
    check("first_fetch", '{1'b0, 3'd5, 3'd0, 4'd3, 4'd4, 3'd0, 1'b0, 1'b0});

    // Vector table: reach step k of an opcode and compare the decoded selects.
    foreach (vecs[i]) begin
      do_reset();
      cyc(1'b0, vecs[i].opc, 1'b0, vecs[i].cf);
      for (int k = 1; k <= vecs[i].k; k++) cyc(1'b0, vecs[i].opc, 1'b0, vecs[i].cf);
      e = '{1'b0, vecs[i].ao, vecs[i].al, vecs[i].o, vecs[i].l, 3'(vecs[i].k), 1'b0, 1'b0};
      check($sformatf("vec%0d", i), e);
    end

    // Three-step opcode: step 0,1,2 then fetch again.
    do_reset();
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("lda_s0", e_fetch(1'b0));
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("lda_s1", e_exec(ref_word(8'h01, 1), 1, 1'b0, 1'b0));
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("lda_s2", e_exec(ref_word(8'h01, 2), 2, 1'b0, 1'b0));
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("lda_refetch", e_fetch(1'b0));

    // Step overflow: err after step 7, sticky across instructions, cleared by reset.
    do_reset();
    run_instr(8'h03, 1'b0, hflag);
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("ovf_fetch", e_fetch(1'b1));
    for (int k = 1; k <= 2; k++) cyc(1'b0, 8'h01, 1'b0, 1'b0);
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("ovf_sticky", e_fetch(1'b1));
    do_reset();

    // Bus request raised mid-instruction: grant only after the eoi step.
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("req_fetch", e_fetch(1'b0));
    cyc(1'b0, 8'h01, 1'b1, 1'b0); check("req_s1", e_exec(ref_word(8'h01, 1), 1, 1'b0, 1'b0));
    cyc(1'b0, 8'h01, 1'b1, 1'b0); check("req_s2", e_exec(ref_word(8'h01, 2), 2, 1'b0, 1'b0));
    cyc(1'b0, 8'h01, 1'b1, 1'b0); check("req_grant", e_idle(1'b1, 1'b0, 1'b0));
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("req_grant_last", e_idle(1'b1, 1'b0, 1'b0));
    cyc(1'b0, 8'h01, 1'b0, 1'b0); check("req_release_fetch", e_fetch(1'b0));

    // Halt, grant from halt, release back to halt.
    do_reset();
    cyc(1'b0, 8'h0F, 1'b1, 1'b0); check("hlt_fetch", e_fetch(1'b0));
    cyc(1'b0, 8'h0F, 1'b1, 1'b0); check("hlt_exec", e_exec(ref_word(8'h0F, 1), 1, 1'b0, 1'b0));
    cyc(1'b0, 8'h00, 1'b0, 1'b0); check("halted", e_idle(1'b0, 1'b1, 1'b0));
    cyc(1'b0, 8'h00, 1'b1, 1'b0); check("halted_req", e_idle(1'b0, 1'b1, 1'b0));
    cyc(1'b0, 8'h00, 1'b0, 1'b0); check("halt_grant", e_idle(1'b1, 1'b1, 1'b0));
    cyc(1'b0, 8'h00, 1'b0, 1'b0); check("halt_return", e_idle(1'b0, 1'b1, 1'b0));
    cyc(1'b0, 8'h00, 1'b0, 1'b0); check("halt_stays", e_idle(1'b0, 1'b1, 1'b0));

    // Reset mid-instruction abandons it.
    do_reset();
    cyc(1'b0, 8'h03, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) cyc(1'b0, 8'h03, 1'b0, 1'b0);
    check("mid_s3", e_exec(ref_word(8'h03, 3), 3, 1'b0, 1'b0));
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    cyc(1'b0, 8'h03, 1'b0, 1'b0); check("mid_reset_idle", e_idle(1'b0, 1'b0, 1'b0));
    cyc(1'b0, 8'h03, 1'b0, 1'b0); check("mid_refetch", e_fetch(1'b0));
    cyc(1'b0, 8'h03, 1'b0, 1'b0); check("mid_restart_s1", e_exec(ref_word(8'h03, 1), 1, 1'b0, 1'b0));

    // Random instruction stream against the reference microprogram.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: opc = 8'h01;
        4, 5:       opc = 8'h02;
        6:          opc = 8'h03;
        7:          opc = 8'h0F;
        default:    opc = 8'h40 + 8'($urandom_range(0, 15));
      endcase
      run_instr(opc, 1'b0, hflag);
      if (hflag) begin
        halt_phase();
        cyc(1'b1, opcode, 1'b0, 1'b0);
        cyc(1'b0, opcode, 1'b0, 1'b0);
        m_err = 1'b0;
        check("rand_reset", e_idle(1'b0, 1'b0, 1'b0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Microstep sequencer for the memory/address datapath. It steps through a fixed fetch step, then per-opcode microcode steps. Each step drives the encoded select fields (`addroutctl`, `addrloadctl`, `outctl`, `loadctl`) consumed by `mem_block` and the other bus devices. Between instructions it can yield both buses to an external loader through a request/grant handshake.

## Interface
Parameters:
- `STEP_W`, default 3: microstep counter width, giving at most 8 steps per instruction.
- `OPC_W`, default 8: opcode width.

Ports:
- `clk` in 1: system clock. All state updates occur on the rising edge.
- `rst` in 1: reset, **synchronous, active-high**.
- `opcode` in `OPC_W`: instruction register contents. Valid from step 1 onward.
- `cond_flag` in 1: condition input used by conditional microcode steps.
- `bus_req` in 1: external request for the address and data buses.
- `bus_grant` out 1: buses yielded, all selects idle.
- `addroutctl` out 3: address-bus driver select.
- `addrloadctl` out 3: address-bus load select.
- `outctl` out 4: data-bus driver select. Bit 3 = 1 disables.
- `loadctl` out 4: data-bus load select. Bit 3 = 1 disables.
- `step` out `STEP_W`: current microstep.
- `halted` out 1: sequencer is in HALT.
- `ucode_err` out 1: sticky flag for step overflow.

## Operation
- **States:** RESET, FETCH, EXEC, HALT, GRANT.
- **Idle encoding:**
  - `addroutctl` = `addrloadctl` = `ADDR_NONE` (0).
  - `outctl` = `loadctl` = 4'b1000.
- **Outputs:** combinational decode of the registered state, `step`, the microcode word and `cond_flag`.
- **RESET:**
  - Entered whenever `rst` = 1.
  - Outputs idle, `step` = 0, `bus_grant` = 0, `halted` = 0, `ucode_err` = 0.
  - Next state is FETCH.
- **FETCH (step 0), fixed word:**
  - `addroutctl` = `ADDR_PC` (5); PC counts because its output is selected.
  - `outctl` = `OUT_MEM` (4'b0011).
  - `loadctl` = `LOAD_IR` (4'b0100).
  - Next state: EXEC with `step` = 1.
- **EXEC:**
  - Each step takes its control word from `microcode_rom[{opcode, step}]`.
  - Word fields: `eoi`, `hlt`, `cond`, `addrout`, `addrload`, `out`, `load`.
- **End of step:**
  - If `hlt` = 1, go to HALT.
  - Else if `eoi` = 1, or `step` is at its maximum (`step` = 7), end the instruction.
  - Else increment `step`.
- **Step overflow:** reaching `step` = 7 without `eoi` forces end of instruction and sets `ucode_err` (sticky until `rst`).
- **End of instruction:** if `bus_req` = 1, go to GRANT; else go to FETCH.
- **HALT:**
  - Outputs idle, `halted` = 1.
  - If `bus_req` = 1, go to GRANT with `halted` held at 1.
  - Otherwise stays in HALT until `rst`.
- **GRANT:**
  - Outputs idle, `bus_grant` = 1.
  - When `bus_req` = 0, return to HALT if entered from HALT, else to FETCH.
- **bus_req sampling:** sampled only at end of instruction or in HALT; never mid-instruction.

## Timing
- One microstep per `clk` cycle.
- Fetch plus N EXEC steps takes N+1 cycles.
- `bus_grant` rises in the cycle after the sampling edge and falls in the cycle after `bus_req` is seen low.
- The first FETCH follows 1 cycle after `rst` deasserts.
- `opcode` must be stable from the edge that ends FETCH until the end of the instruction.
- **Reset mid-instruction:** the instruction is abandoned. No partial step is re-driven, and selects go idle at the next edge.
- **Simultaneous `hlt` and `eoi`:** `hlt` wins.
- **`bus_req` during EXEC:** ignored until end of instruction.

## Configuration
- `BUS_SEQ_COND_EN`:
  - Defined: an EXEC word with `cond` = 1 and `cond_flag` = 0 forces `addrload` and `load` to idle while still driving `addrout` and `out`. Step advance is unchanged.
  - Undefined: the `cond` bit is ignored and `cond_flag` is unused.

## Structure
- Package `bus_seq_pkg` holds:
  - the state enum;
  - the control-word struct;
  - select constants `ADDR_NONE`, `ADDR_PC`, `OUT_MEM`, `LOAD_MEM`, `LOAD_IR`, `SEL_IDLE`.
- Sub-module `microcode_rom`: a combinational lookup from `{opcode, step}` to the control word. Undefined entries return `eoi` = 1 with idle selects.

## Test plan
- **Reset and fetch:** `rst` for 2 cycles, then release. Cycle 1 after release: `addroutctl` = 5, `outctl` = 3, `loadctl` = 4, `step` = 0.
- **Three-step opcode:** `eoi` on step 2, so `step` goes 0, 1, 2, 0. The FETCH word reappears on cycle 4 and `ucode_err` = 0.
- **Step overflow:** opcode with no `eoi`. `step` reaches 7, the next state is FETCH and `ucode_err` = 1, held until `rst`.
- **Bus request:** `bus_req` asserted mid-instruction. `bus_grant` rises only after the `eoi` step and all selects are idle. Drop `bus_req` and the next cycle is FETCH.
- **Halt:** `hlt` word gives `halted` = 1 with selects idle.
  - Then `bus_req` = 1 gives `bus_grant` = 1.
  - Release returns to HALT, not FETCH.
- **Conditional step (`BUS_SEQ_COND_EN`):** `cond` step with `cond_flag` = 0 gives `loadctl` = 8 and `addrloadctl` = 0. With `cond_flag` = 1, the ROM values pass through.
